// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl: rising-edge interrupt latch with a per-line mask and a
// fixed-priority (highest index wins) req/ack grant to one consumer.
// Optional build macro IRQ_PREEMPT_EN: lets a higher-index eligible line
// replace the outstanding grant id before it is acknowledged.
module irq_priority_ctrl #(
    parameter int N_IRQ = 3,
    parameter int ID_W  = $clog2(N_IRQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] irq_mask,
    output logic             int_req,
    output logic [ID_W-1:0]  int_id,
    input  logic             int_ack,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] lost
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP
    } state_t;

    state_t           state_q;
    logic             int_req_q;
    logic [ID_W-1:0]  int_id_q;
    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] lost_q, lost_d;
    logic [N_IRQ-1:0] edge_v;
    logic [N_IRQ-1:0] clr_v;
    logic [N_IRQ-1:0] elig;
    logic [ID_W-1:0]  winner;

    // Edge detect, service clear and next pending/lost (a new edge beats a clear)
    always_comb begin
        edge_v = irq_in & ~irq_q;
        clr_v  = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            clr_v[i] = (state_q == REQ) && int_ack && (int_id_q == ID_W'(i));
        end
        pending_d = edge_v | (pending_q & ~clr_v);
        lost_d    = lost_q | (edge_v & pending_q & ~clr_v);
    end

    // Highest-index unmasked pending line
    always_comb begin
        elig   = pending_q & ~irq_mask;
        winner = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (elig[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    // Input history, pending and sticky lost registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q     <= '0;
            pending_q <= '0;
            lost_q    <= '0;
        end else begin
            irq_q     <= irq_in;
            pending_q <= pending_d;
            lost_q    <= lost_d;
        end
    end

    // Grant FSM with registered int_req/int_id
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            int_req_q <= 1'b0;
            int_id_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    int_req_q <= 1'b0;
                    if (|elig) begin
                        int_id_q  <= winner;
                        int_req_q <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    // Ack wins over preemption: it retires the id the consumer saw.
                    if (int_ack) begin
                        int_req_q <= 1'b0;
                        state_q   <= GAP;
                    end
`ifdef IRQ_PREEMPT_EN
                    else if (winner > int_id_q) begin
                        int_id_q <= winner;
                    end
`endif
                end
                GAP: begin
                    int_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    int_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign int_req = int_req_q;
    assign int_id  = int_id_q;
    assign pending = pending_q;
    assign lost    = lost_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Bench for irq_priority_ctrl (N_IRQ=3): directed scenarios plus random
// traffic, all checked against a behavioural model of the interrupt rules.
module tb_irq_priority_ctrl;

    localparam int N    = 3;
    localparam int ID_W = 2;
`ifdef IRQ_PREEMPT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    irq_in;
    logic [N-1:0]    irq_mask;
    logic            int_req;
    logic [ID_W-1:0] int_id;
    logic            int_ack;
    logic [N-1:0]    pending;
    logic [N-1:0]    lost;

    int tests = 0;
    int fails = 0;

    // Model state: previous input level, pending/lost flags, grant outstanding,
    // granted line, and quiet cycles still owed after an accepted grant.
    bit m_prev [N];
    bit m_pend [N];
    bit m_lost [N];
    bit m_busy;
    int m_id;
    int m_cool;

    irq_priority_ctrl #(.N_IRQ(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .irq_in   (irq_in),
        .irq_mask (irq_mask),
        .int_req  (int_req),
        .int_id   (int_id),
        .int_ack  (int_ack),
        .pending  (pending),
        .lost     (lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_prev[i] = 0;
            m_pend[i] = 0;
            m_lost[i] = 0;
        end
        m_busy = 0;
        m_id   = 0;
        m_cool = 0;
    endtask

    // One clock of the interrupt rules applied to the inputs present at the edge.
    task automatic model_clock();
        int top;
        bit took, e, clr;
        top = -1;
        for (int i = 0; i < N; i++) if (m_pend[i] && !irq_mask[i]) top = i;
        took = m_busy && int_ack;
        for (int i = 0; i < N; i++) begin
            e   = irq_in[i] && !m_prev[i];
            clr = took && (m_id == i);
            if (e && m_pend[i] && !clr) m_lost[i] = 1;
            if (e) m_pend[i] = 1;
            else if (clr) m_pend[i] = 0;
            m_prev[i] = irq_in[i];
        end
        if (m_busy) begin
            if (took) begin
                m_busy = 0;
                m_cool = 1;
            end else if (PRE && top > m_id) begin
                m_id = top;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (top >= 0) begin
            m_busy = 1;
            m_id   = top;
        end
    endtask

    function automatic logic [N-1:0] vec(input bit a [N]);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = a[i];
        return v;
    endfunction

    task automatic model_compare(input string tag);
        check({tag, ".req"},  32'(int_req), 32'(m_busy));
        check({tag, ".pend"}, 32'(pending), 32'(vec(m_pend)));
        check({tag, ".lost"}, 32'(lost),    32'(vec(m_lost)));
        if (m_busy) check({tag, ".id"}, 32'(int_id), 32'(m_id));
    endtask

    // Advance one clock, update the model, then sample 1 ns after the edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        model_compare(tag);
    endtask

    initial begin
        reset    = 1'b1;
        irq_in   = '0;
        irq_mask = '0;
        int_ack  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst.req",  32'(int_req), 0);
        check("rst.id",   32'(int_id),  0);
        check("rst.pend", 32'(pending), 0);
        check("rst.lost", 32'(lost),    0);
        #3 reset = 1'b0;

        // Single pulse on line 0, ack on the fourth clock
        irq_in = 3'b001; tick("t1.c1");
        check("t1.pend_after_edge", 32'(pending), 32'h1);
        check("t1.no_req_yet", 32'(int_req), 0);
        irq_in = 3'b000; tick("t1.c2");
        check("t1.req", 32'(int_req), 1);
        check("t1.id",  32'(int_id),  0);
        tick("t1.c3");
        int_ack = 1'b1; tick("t1.c4");
        check("t1.req_drop", 32'(int_req), 0);
        check("t1.pend_clr", 32'(pending), 0);
        int_ack = 1'b0; tick("t1.c5");
        tick("t1.c6");
        check("t1.stays_idle", 32'(int_req), 0);

        // Simultaneous edges on lines 2 and 0: 2 first, then 0 after the gap
        irq_in = 3'b101; tick("t2.c1");
        irq_in = 3'b000; tick("t2.c2");
        check("t2.first_id", 32'(int_id), 2);
        int_ack = 1'b1; tick("t2.ack1");
        int_ack = 1'b0; tick("t2.gap");
        check("t2.gap_low", 32'(int_req), 0);
        tick("t2.regrant");
        check("t2.second_id", 32'(int_id), 0);
        int_ack = 1'b1; tick("t2.ack2");
        int_ack = 1'b0;
        check("t2.pend_empty", 32'(pending), 0);
        tick("t2.tail");

        // Masked line 2 keeps pending and is served once unmasked
        irq_mask = 3'b100; irq_in = 3'b111; tick("t3.c1");
        irq_in = 3'b000; tick("t3.c2");
        check("t3.masked_win", 32'(int_id), 1);
        int_ack = 1'b1; tick("t3.ack1");
        int_ack = 1'b0; tick("t3.gap1");
        tick("t3.grant0");
        int_ack = 1'b1; tick("t3.ack2");
        int_ack = 1'b0;
        check("t3.still_pend2", 32'(pending), 32'h4);
        irq_mask = 3'b000; tick("t3.gap2");
        tick("t3.grant2");
        check("t3.unmasked_id", 32'(int_id), 2);
        int_ack = 1'b1; tick("t3.ack3");
        int_ack = 1'b0; tick("t3.tail");

        // Lost flag, and an edge coinciding with the ack of the same line
        irq_in = 3'b010; tick("t4.c1");
        irq_in = 3'b000; tick("t4.c2");
        irq_in = 3'b010; tick("t4.dup_edge");
        check("t4.lost_set", 32'(lost), 32'h2);
        irq_in = 3'b000; int_ack = 1'b1; tick("t4.ack1");
        int_ack = 1'b0; tick("t4.gap1");
        tick("t4.idle");
        irq_in = 3'b010; tick("t4.edge2");
        irq_in = 3'b000; tick("t4.grant");
        irq_in = 3'b010; int_ack = 1'b1; tick("t4.ack_and_edge");
        check("t4.set_wins", 32'(pending), 32'h2);
        check("t4.lost_sticky", 32'(lost), 32'h2);
        irq_in = 3'b000; int_ack = 1'b0; tick("t4.gap2");
        tick("t4.regrant");
        check("t4.second_id1", 32'(int_id), 1);
        int_ack = 1'b1; tick("t4.ack2");
        int_ack = 1'b0; tick("t4.tail");

        // Async reset while a request is outstanding
        irq_in = 3'b011; tick("t5.c1");
        tick("t5.c2");
        check("t5.req_up", 32'(int_req), 1);
        #2 reset = 1'b1;
        #1;
        check("t5.async_req", 32'(int_req), 0);
        check("t5.async_pend", 32'(pending), 0);
        check("t5.lost_cleared", 32'(lost), 0);
        model_reset();
        irq_in = 3'b000;
        @(negedge clk) reset = 1'b0;
        tick("t5.r1");
        tick("t5.r2");
        tick("t5.r3");
        check("t5.no_grant", 32'(int_req), 0);

        // Higher line arriving during an outstanding grant
        irq_in = 3'b001; tick("t6.c1");
        irq_in = 3'b000; tick("t6.grant0");
        irq_in = 3'b100; tick("t6.edge2");
        irq_in = 3'b000; tick("t6.after");
        check("t6.id_after_edge", 32'(int_id), PRE ? 2 : 0);
        check("t6.req_held", 32'(int_req), 1);
        int_ack = 1'b1; tick("t6.ack1");
        check("t6.pend_left", 32'(pending), PRE ? 32'h1 : 32'h4);
        int_ack = 1'b0; tick("t6.gap");
        tick("t6.regrant");
        check("t6.second_id", 32'(int_id), PRE ? 0 : 2);
        int_ack = 1'b1; tick("t6.ack2");
        int_ack = 1'b0; tick("t6.tail");

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            irq_in  = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 7)) : irq_in;
            if ($urandom_range(0, 15) == 0) irq_mask = N'($urandom_range(0, 7));
            int_ack = ($urandom_range(0, 2) == 0);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
